// File: rtl/volume_pkg.sv
// Shared constants and types for the volume/attenuation stage.
package volume_pkg;

    localparam int unsigned sample_width_lp = 24;
    localparam int unsigned shift_width_lp  = 8;
    localparam int unsigned min_shift_lp    = 1;
    localparam int unsigned max_shift_lp    = 7;
    localparam int unsigned reset_shift_lp  = 3;

    typedef logic [sample_width_lp-1:0] sample_t;
    typedef logic [shift_width_lp-1:0]  shift_t;

endpackage : volume_pkg

// File: rtl/volume_sat_counter.sv
// Up/down saturating counter holding the current attenuation shift.
module volume_sat_counter
    import volume_pkg::*;
#(
    parameter int unsigned min_shift_p   = min_shift_lp,
    parameter int unsigned max_shift_p   = max_shift_lp,
    parameter int unsigned reset_shift_p = reset_shift_lp
) (
    input  logic   clk_i,
    input  logic   reset_i,
    input  logic   up_i,
    input  logic   down_i,
    output shift_t shift_r
);

    localparam shift_t min_lp   = shift_t'(min_shift_p);
    localparam shift_t max_lp   = shift_t'(max_shift_p);
    localparam shift_t reset_lp = shift_t'(reset_shift_p);

    shift_t shift_n;

    // Next shift: step once per cycle on a lone request, saturating at the bounds.
    always_comb begin
        shift_n = shift_r;
        case ({up_i, down_i})
            2'b10: if (shift_r < max_lp) shift_n = shift_r + shift_t'(1);
            2'b01: if (shift_r > min_lp) shift_n = shift_r - shift_t'(1);
            default: shift_n = shift_r;
        endcase
    end

    // Shift register; reset reloads the default level without waiting for a clock.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            shift_r <= reset_lp;
        end else begin
            shift_r <= shift_n;
        end
    end

endmodule : volume_sat_counter

// File: rtl/volume_ctrl.sv
// Digital attenuation stage: input sample logically right-shifted by a stepped level.
module volume_ctrl
    import volume_pkg::*;
#(
    parameter int unsigned width_p       = sample_width_lp,
    parameter int unsigned min_shift_p   = min_shift_lp,
    parameter int unsigned max_shift_p   = max_shift_lp,
    parameter int unsigned reset_shift_p = reset_shift_lp
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] sound_i,
    input  logic               up_i,
    input  logic               down_i,
    output logic [width_p-1:0] sound_o
);

    shift_t shift_r;

    volume_sat_counter #(
        .min_shift_p   (min_shift_p),
        .max_shift_p   (max_shift_p),
        .reset_shift_p (reset_shift_p)
    ) u_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .up_i    (up_i),
        .down_i  (down_i),
        .shift_r (shift_r)
    );

    // Zero-latency attenuation; vacated upper bits fill with zeros.
    assign sound_o = sound_i >> shift_r;

endmodule : volume_ctrl

// File: tb/tb_volume_ctrl.sv
// Self-checking bench for volume_ctrl against an arithmetic attenuation model.
module tb_volume_ctrl;

    logic        clk;
    logic        reset;
    logic [23:0] sound_in;
    logic        up;
    logic        down;
    logic [23:0] sound_out;

    int shift_m;
    int checks;
    int fails;

    volume_ctrl dut (
        .clk_i   (clk),
        .reset_i (reset),
        .sound_i (sound_in),
        .up_i    (up),
        .down_i  (down),
        .sound_o (sound_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attenuation as division by a power of two.
    function automatic logic [23:0] atten(input logic [23:0] s, input int sh);
        int unsigned v;
        v = int'(s) / (32'd1 << sh);
        return 24'(v);
    endfunction

    // Apply controls for one clock edge and advance the model (clamped level).
    task automatic cycle(input logic u, input logic d);
        int nxt;
        up   = u;
        down = d;
        @(posedge clk);
        #1;
        nxt = shift_m + int'(u) - int'(d);
        if (nxt < 1) nxt = 1;
        if (nxt > 7) nxt = 7;
        shift_m = nxt;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        up       = 1'b0;
        down     = 1'b0;
        sound_in = 24'h000000;
        shift_m  = 3;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (sound_out !== 24'h000000) begin
            fails++;
            $display("FAIL reset_zero got %h want %h", sound_out, 24'h000000);
        end
        sound_in = 24'hFFFFFF;
        #1;
        checks++;
        if (sound_out !== 24'h1FFFFF) begin
            fails++;
            $display("FAIL reset_shift3 got %h want %h", sound_out, 24'h1FFFFF);
        end
        up = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (sound_out !== 24'h1FFFFF) begin
            fails++;
            $display("FAIL reset_held got %h want %h", sound_out, 24'h1FFFFF);
        end
        up       = 1'b0;
        reset    = 1'b0;
        sound_in = 24'h000010;
        #1;
        checks++;
        if (sound_out !== 24'h000002) begin
            fails++;
            $display("FAIL reset_release got %h want %h", sound_out, 24'h000002);
        end
    endtask

    task automatic test_down_sat();
        logic [23:0] want [3];
        want[0] = 24'h3FFFFF;
        want[1] = 24'h7FFFFF;
        want[2] = 24'h7FFFFF;
        sound_in = 24'hFFFFFF;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1);
            checks++;
            if (sound_out !== want[i]) begin
                fails++;
                $display("FAIL down_step%0d got %h want %h", i, sound_out, want[i]);
            end
        end
        sound_in = 24'h000002;
        #1;
        checks++;
        if (sound_out !== 24'h000001) begin
            fails++;
            $display("FAIL down_min got %h want %h", sound_out, 24'h000001);
        end
    endtask

    task automatic test_simultaneous();
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        sound_in = 24'h000004;
        #1;
        checks++;
        if (sound_out !== 24'h000001) begin
            fails++;
            $display("FAIL simultaneous got %h want %h", sound_out, 24'h000001);
        end
        cycle(1'b0, 1'b0);
        checks++;
        if (sound_out !== 24'h000001) begin
            fails++;
            $display("FAIL idle_hold got %h want %h", sound_out, 24'h000001);
        end
    endtask

    task automatic test_up_step();
        logic [1:0] ctl [6];
        int         lvl [6];
        ctl = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10};
        lvl = '{3, 4, 5, 4, 3, 4};
        for (int i = 0; i < 6; i++) begin
            sound_in = 24'($urandom);
            cycle(ctl[i][1], ctl[i][0]);
            checks++;
            if (sound_out !== 24'(sound_in >> lvl[i])) begin
                fails++;
                $display("FAIL up_step%0d got %h want %h", i, sound_out, 24'(sound_in >> lvl[i]));
            end
        end
        sound_in = 24'h00000A;
        #1;
        checks++;
        if (sound_out !== 24'h000000) begin
            fails++;
            $display("FAIL shift4_small got %h want %h", sound_out, 24'h000000);
        end
    endtask

    task automatic test_up_sat();
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);
        sound_in = 24'hFFFFFF;
        #1;
        checks++;
        if (sound_out !== 24'h01FFFF) begin
            fails++;
            $display("FAIL up_max got %h want %h", sound_out, 24'h01FFFF);
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, 1'b1);
        sound_in = 24'h000080;
        #1;
        checks++;
        if (sound_out !== 24'h000002) begin
            fails++;
            $display("FAIL at_shift6 got %h want %h", sound_out, 24'h000002);
        end
        up    = 1'b0;
        down  = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (sound_out !== 24'h000010) begin
            fails++;
            $display("FAIL async_reset got %h want %h", sound_out, 24'h000010);
        end
        reset   = 1'b0;
        shift_m = 3;
        #1;
        checks++;
        if (sound_out !== 24'h000010) begin
            fails++;
            $display("FAIL async_release got %h want %h", sound_out, 24'h000010);
        end
    endtask

    task automatic test_random();
        logic [23:0] want;
        for (int i = 0; i < 300; i++) begin
            sound_in = 24'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                #1;
                reset = 1'b1;
                #1;
                reset   = 1'b0;
                shift_m = 3;
            end
            cycle(1'($urandom), 1'($urandom));
            want = atten(sound_in, shift_m);
            checks++;
            if (sound_out !== want) begin
                fails++;
                $display("FAIL random%0d got %h want %h (model shift %0d)", i, sound_out, want, shift_m);
            end
            sound_in = 24'($urandom);
            #1;
            want = atten(sound_in, shift_m);
            checks++;
            if (sound_out !== want) begin
                fails++;
                $display("FAIL random_comb%0d got %h want %h", i, sound_out, want);
            end
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_down_sat();
        test_simultaneous();
        test_up_step();
        test_up_sat();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule : tb_volume_ctrl
